iq_age_select: RTL

IQ_AGE_SELECT -- requirements
Module: iq_age_select

---
 rtl/iq_age_select_if.sv | 25 ++
 rtl/iq_age_select.sv | 126 ++++++++++++
 2 files changed

// File: rtl/iq_age_select_if.sv
// Issue-queue selector bundle: allocation/ready inputs, issue slot and free-entry outputs.
interface iq_age_select_if #(
   parameter int IQ_DEPTH = 4,
   parameter int IDX_W    = $clog2(IQ_DEPTH)
);
   logic [IQ_DEPTH-1:0] alloc_i;
   logic [IQ_DEPTH-1:0] entry_ready_i;
   logic                issue_ready_i;
   logic [IQ_DEPTH-1:0] select_o;
   logic                issue_valid_o;
   logic [IDX_W-1:0]    issue_idx_o;
   logic                free_valid_o;
   logic [IDX_W-1:0]    free_idx_o;
   logic                full_o;

   modport master (
      output alloc_i, entry_ready_i, issue_ready_i,
      input  select_o, issue_valid_o, issue_idx_o, free_valid_o, free_idx_o, full_o
   );

   modport slave (
      input  alloc_i, entry_ready_i, issue_ready_i,
      output select_o, issue_valid_o, issue_idx_o, free_valid_o, free_idx_o, full_o
   );
endinterface

// File: rtl/iq_age_select.sv
// Issue-queue selector: occupancy tracking, oldest-ready pick into a one-deep issue slot.
// IQ_AGE_SELECT_EN defined: age-matrix oldest-first pick; undefined: lowest-index pick.
module iq_age_select #(
   parameter int IQ_DEPTH = 4,
   parameter int IDX_W    = $clog2(IQ_DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   iq_age_select_if.slave bus
);

   logic [IQ_DEPTH-1:0] occ_r;
   logic [IQ_DEPTH-1:0] cand_s;
   logic [IQ_DEPTH-1:0] oldest_s;
   logic [IQ_DEPTH-1:0] select_s;
   logic [IQ_DEPTH-1:0] alloc_eff_s;
   logic                accept_s;
   logic                issue_valid_r;
   logic [IDX_W-1:0]    issue_idx_r;
   logic [IDX_W-1:0]    sel_idx_s;
   logic [IDX_W-1:0]    free_idx_s;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [IQ_DEPTH-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int k = 0; k < IQ_DEPTH; k++) begin
         idx = idx | (vec[k] ? IDX_W'(k) : {IDX_W{1'b0}});
      end
      return idx;
   endfunction

   // Candidate set, slot acceptance and effective (unoccupied-target) allocations
   always_comb begin
      cand_s      = occ_r & bus.entry_ready_i;
      accept_s    = ~issue_valid_r | bus.issue_ready_i;
      alloc_eff_s = bus.alloc_i & ~occ_r;
   end

`ifdef IQ_AGE_SELECT_EN
   logic [IQ_DEPTH-1:0] older_r [IQ_DEPTH];

   // A candidate wins when no other candidate is older than it
   always_comb begin
      logic blocked;
      oldest_s = {IQ_DEPTH{1'b0}};
      for (int i = 0; i < IQ_DEPTH; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < IQ_DEPTH; j++) begin
            blocked = blocked | (cand_s[j] & older_r[j][i]);
         end
         oldest_s[i] = cand_s[i] & ~blocked;
      end
   end

   // New entry is youngest: its row clears, surviving occupants become older than it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IQ_DEPTH; i++) older_r[i] <= {IQ_DEPTH{1'b0}};
      end else if (flush) begin
         for (int i = 0; i < IQ_DEPTH; i++) older_r[i] <= {IQ_DEPTH{1'b0}};
      end else begin
         for (int k = 0; k < IQ_DEPTH; k++) begin
            if (alloc_eff_s[k]) begin
               older_r[k] <= {IQ_DEPTH{1'b0}};
               for (int j = 0; j < IQ_DEPTH; j++) begin
                  if (occ_r[j] & ~select_s[j]) older_r[j][k] <= 1'b1;
               end
            end
         end
      end
   end
`else
   // Lowest set bit of the candidate vector
   always_comb begin
      oldest_s = cand_s & (~cand_s + {{(IQ_DEPTH-1){1'b0}}, 1'b1});
   end
`endif

   // Select is suppressed while the slot is stalled, when nothing is ready, or on flush
   always_comb begin
      select_s = {IQ_DEPTH{1'b0}};
      if (accept_s && !flush && (|cand_s)) begin
         select_s = oldest_s;
      end else begin
         select_s = {IQ_DEPTH{1'b0}};
      end
      sel_idx_s = onehot_to_idx(select_s);
   end

   // Lowest unoccupied entry; scanning downward leaves the smallest index last
   always_comb begin
      free_idx_s = {IDX_W{1'b0}};
      for (int k = IQ_DEPTH - 1; k >= 0; k--) begin
         free_idx_s = occ_r[k] ? free_idx_s : IDX_W'(k);
      end
   end

   // Occupancy and the registered issue slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r         <= {IQ_DEPTH{1'b0}};
         issue_valid_r <= 1'b0;
         issue_idx_r   <= {IDX_W{1'b0}};
      end else if (flush) begin
         occ_r         <= {IQ_DEPTH{1'b0}};
         issue_valid_r <= 1'b0;
      end else begin
         occ_r <= (occ_r & ~select_s) | alloc_eff_s;
         if (|select_s) begin
            issue_valid_r <= 1'b1;
            issue_idx_r   <= sel_idx_s;
         end else if (bus.issue_ready_i) begin
            issue_valid_r <= 1'b0;
         end
      end
   end

   assign bus.select_o      = select_s;
   assign bus.issue_valid_o = issue_valid_r;
   assign bus.issue_idx_o   = issue_idx_r;
   assign bus.free_valid_o  = |(~occ_r);
   assign bus.full_o        = &occ_r;
   assign bus.free_idx_o    = free_idx_s;

endmodule
